// File: rtl/bin_to_bcd_scheduler.sv
// Shared round-robin binary-to-BCD converter: one double-dabble iteration per cycle, WIDTH+1 cycles grant-to-valid.
// Result is held in DONE until out_ready; no new grant is issued while busy.
module bin_to_bcd_scheduler #(
  parameter int NREQ   = 4,
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10,
  parameter int IDW    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WIDTH-1:0]    bin_in,
  output logic [NREQ-1:0]          gnt,
  output logic                     busy,
  output logic [4*DIGITS-1:0]      bcd_out,
  output logic [IDW-1:0]           out_id,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IDW-1:0]    ptr;
  logic [IDW-1:0]    win;
  logic              found;
  logic [WIDTH-1:0]  opnd_sel;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  opnd;
  logic [BW-1:0]     acc;
  logic [BW-1:0]     acc_adj;
  logic [BW-1:0]     acc_shift;
  logic              last;

  // Two descending passes: requesters at or above the pointer override those below it,
  // so the lowest index at/after the pointer wins, otherwise the lowest index overall.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i] && (i < int'(ptr))) begin
        found = 1'b1;
        win   = IDW'(i);
      end
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i] && (i >= int'(ptr))) begin
        found = 1'b1;
        win   = IDW'(i);
      end
    end
  end

  always_comb begin
    opnd_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (i == int'(win)) begin
        opnd_sel = bin_in[i*WIDTH +: WIDTH];
      end
    end
  end

  // Per-digit add-3 correction; digits are independent, no carry between nibbles.
  always_comb begin
    acc_adj = acc;
    for (int d = 0; d < DIGITS; d++) begin
      if (acc[4*d +: 4] >= 4'd5) begin
        acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
      end
    end
  end

  assign acc_shift = {acc_adj[BW-2:0], opnd[WIDTH-1]};
  assign last      = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found)     state_nxt = SHIFT;
      SHIFT:   if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt = '0;
    if ((state == IDLE) && found) begin
      gnt[win] = 1'b1;
    end
    busy      = (state != IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      cnt     <= '0;
      opnd    <= '0;
      acc     <= '0;
      bcd_out <= '0;
      out_id  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            opnd   <= opnd_sel;
            acc    <= '0;
            out_id <= win;
            cnt    <= '0;
            if (int'(win) == NREQ - 1) begin
              ptr <= '0;
            end else begin
              ptr <= win + 1'b1;
            end
          end
        end
        SHIFT: begin
          acc  <= acc_shift;
          opnd <= {opnd[WIDTH-2:0], 1'b0};
          if (last) begin
            cnt     <= '0;
            bcd_out <= acc_shift;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_scheduler.sv
// Directed bench for bin_to_bcd_scheduler: latency, conversion values, round-robin order,
// backpressure hold and mid-conversion reset, all against hand-computed BCD constants.
module tb_bin_to_bcd_scheduler;

  logic         clk;
  logic         rst;
  logic [3:0]   req;
  logic [127:0] bin_in;
  logic [3:0]   gnt;
  logic         busy;
  logic [39:0]  bcd_out;
  logic [1:0]   out_id;
  logic         out_valid;
  logic         out_ready;

  int checks;
  int errors;
  int cyc;

  bin_to_bcd_scheduler #(.NREQ(4), .WIDTH(32), .DIGITS(10), .IDW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .bin_in    (bin_in),
    .gnt       (gnt),
    .busy      (busy),
    .bcd_out   (bcd_out),
    .out_id    (out_id),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running required finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_gnt(output int t);
    t = -1;
    for (int n = 0; n < 300; n++) begin
      #1;
      if (gnt != 4'b0) begin
        t = cyc;
        break;
      end
      @(negedge clk);
    end
    if (t < 0) chk("gnt_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_valid(output int t);
    t = -1;
    for (int n = 0; n < 300; n++) begin
      #1;
      if (out_valid) begin
        t = cyc;
        break;
      end
      @(negedge clk);
    end
    if (t < 0) chk("valid_timeout", 64'd0, 64'd1);
  endtask

  // Single-requester conversion with out_ready high; operand is scrambled after the grant edge.
  task automatic run_one(input int id, input logic [31:0] val, input logic [39:0] exp_bcd);
    int tg;
    int tv;
    bin_in[id*32 +: 32] = val;
    req = 4'b0001 << id;
    wait_gnt(tg);
    chk("gnt_onehot", 64'(gnt), 64'(1) << id);
    @(negedge clk);
    #1;
    chk("gnt_single", 64'(gnt), 64'd0);
    chk("busy_shift", 64'(busy), 64'd1);
    req = 4'b0;
    bin_in[id*32 +: 32] = ~val;
    wait_valid(tv);
    chk("latency", 64'(tv - tg), 64'd33);
    chk("bcd", 64'(bcd_out), 64'(exp_bcd));
    chk("out_id", 64'(out_id), 64'(id));
    @(negedge clk);
    #1;
    chk("valid_clr", 64'(out_valid), 64'd0);
  endtask

  logic [39:0] rr_bcd [4];
  int          rr_order [5];

  initial begin
    int tg;
    int tv;
    int tprev;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    req       = 4'b0;
    bin_in    = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_bcd", 64'(bcd_out), 64'd0);
    chk("rst_id", 64'(out_id), 64'd0);
    @(negedge clk);

    run_one(0, 32'd0,          40'h0000000000);
    run_one(2, 32'hFFFFFFFF,   40'h4294967295);
    run_one(1, 32'd12345678,   40'h0012345678);
    run_one(1, 32'd1000000000, 40'h1000000000);
    run_one(1, 32'd9,          40'h0000000009);

    // Round robin from a freshly reset pointer with all requesters held.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bin_in[0*32 +: 32] = 32'd7;
    bin_in[1*32 +: 32] = 32'd100;
    bin_in[2*32 +: 32] = 32'd65535;
    bin_in[3*32 +: 32] = 32'd999999999;
    rr_bcd[0] = 40'h0000000007;
    rr_bcd[1] = 40'h0000000100;
    rr_bcd[2] = 40'h0000065535;
    rr_bcd[3] = 40'h0999999999;
    rr_order  = '{0, 1, 2, 3, 0};
    req   = 4'b1111;
    tprev = -1;
    for (int g = 0; g < 5; g++) begin
      wait_gnt(tg);
      chk("rr_gnt", 64'(gnt), 64'(1) << rr_order[g]);
      if (g > 0) chk("rr_gap", 64'(tg - tprev), 64'd34);
      tprev = tg;
      @(negedge clk);
      wait_valid(tv);
      chk("rr_id", 64'(out_id), 64'(rr_order[g]));
      chk("rr_bcd", 64'(bcd_out), 64'(rr_bcd[rr_order[g]]));
    end
    req = 4'b0;
    @(negedge clk);

    // Backpressure: result held while req[3] waits; grant to 3 right after acceptance.
    out_ready = 1'b0;
    bin_in[0*32 +: 32] = 32'd55;
    bin_in[3*32 +: 32] = 32'd4321;
    req = 4'b0001;
    wait_gnt(tg);
    chk("bp_gnt0", 64'(gnt), 64'h1);
    @(negedge clk);
    req = 4'b1000;
    wait_valid(tv);
    for (int k = 0; k < 5; k++) begin
      chk("bp_bcd", 64'(bcd_out), 64'h55);
      chk("bp_id", 64'(out_id), 64'd0);
      chk("bp_busy", 64'(busy), 64'd1);
      chk("bp_nognt", 64'(gnt), 64'd0);
      chk("bp_valid", 64'(out_valid), 64'd1);
      @(negedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("bp_gnt3", 64'(gnt), 64'h8);
    chk("bp_valid_clr", 64'(out_valid), 64'd0);
    @(negedge clk);
    req = 4'b0;
    wait_valid(tv);
    chk("bp_bcd3", 64'(bcd_out), 64'h4321);
    chk("bp_id3", 64'(out_id), 64'd3);
    @(negedge clk);

    // Reset during SHIFT iteration 10 abandons the conversion and rewinds the pointer.
    bin_in[0*32 +: 32] = 32'd2024;
    req = 4'b1111;
    wait_gnt(tg);
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mr_valid", 64'(out_valid), 64'd0);
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_bcd", 64'(bcd_out), 64'd0);
    chk("mr_gnt", 64'(gnt), 64'h1);
    @(negedge clk);
    req = 4'b0;
    wait_valid(tv);
    chk("mr_res", 64'(bcd_out), 64'h2024);
    chk("mr_id", 64'(out_id), 64'd0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_scheduler.md
Name: bin_to_bcd_scheduler

Overview:
Shared, time-multiplexed binary-to-BCD conversion engine for the conversions subsystem. Accepts unsigned binary values from NREQ requesters, arbitrates round-robin, and converts one value at a time with a sequential shift-and-add-3 (double-dabble) datapath. Returns packed BCD digits plus the requester ID over a valid/ready output handshake. Replaces per-requester combinational converters with a single iterative unit.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 32, binary operand width in bits
DIGITS, 10, number of BCD output digits; must satisfy 10^DIGITS > 2^WIDTH-1
IDW, 2, width of requester ID; equals ceil(log2(NREQ))

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
req  in  NREQ  per-requester conversion request; level, held until granted
bin_in  in  NREQ*WIDTH  operands, requester i in bits [i*WIDTH +: WIDTH]
gnt  out  NREQ  one-hot, single-cycle grant; operand captured on that edge
busy  out  1  high whenever state is not IDLE
bcd_out  out  4*DIGITS  result, digit k (10^k) in bits [4k+3:4k]
out_id  out  IDW  requester index owning bcd_out
out_valid  out  1  result valid; held until accepted
out_ready  in  1  downstream accept

Behaviour:
- Clock/reset: one clock domain, clk; rst synchronous, active-high.
- Reset values: gnt=0, busy=0, out_valid=0, bcd_out=0, out_id=0, round-robin pointer=0, state=IDLE, iteration counter=0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - If req is all zero, stay in IDLE.
  - Otherwise, search from the pointer upward with wrap-around. The first set req[i] wins.
  - gnt[i] is asserted combinationally in that cycle.
  - On the edge: capture bin_in[i] into the shift register, clear the BCD accumulator, latch out_id=i, set pointer=(i+1) mod NREQ, set counter=0, go to SHIFT.
- gnt is never asserted outside IDLE. At most one gnt bit is set per cycle.
- Requesters may drop req before being granted (withdraw) with no side effect.
- SHIFT: one iteration per cycle, WIDTH cycles in total.
  - Each iteration: every BCD digit >=5 gets +3 (all digits in parallel, 4-bit, no carry between digits).
  - Then the {accumulator, operand} register shifts left 1; the operand MSB enters accumulator bit 0.
  - counter increments each iteration.
  - After the iteration with counter==WIDTH-1, go to DONE and register bcd_out.
- DONE:
  - out_valid=1. bcd_out and out_id stay stable until the cycle where out_valid&&out_ready.
  - On that cycle: clear out_valid and go to IDLE.
  - The next grant can occur at the earliest in the following cycle.
- Latency: grant in cycle T gives out_valid first high in cycle T+WIDTH+1. Throughput is one conversion per WIDTH+2 cycles with out_ready tied high.
- Arithmetic: unsigned only. bin_in=2^WIDTH-1 converts exactly. No overflow is possible given the DIGITS constraint.
- Simultaneous events: out_ready asserted in IDLE or SHIFT is ignored. bin_in changes after the grant edge do not affect the conversion in progress.
- Reset mid-operation (any state): the conversion is abandoned with no output. All registers return to reset values, and the pointer returns to 0.

Test Plan:
- Single request, req=0001, bin_in[0]=0 -> gnt=0001 for one cycle; out_valid at grant+33; bcd_out=0, out_id=0.
- Max value, req[2] only, value 4294967295 -> bcd_out=0x4294967295 (digit nibbles), out_id=2, latency exactly 33 cycles.
- Typical value, req[1], value 12345678 -> bcd_out=0x0012345678. Repeat with 1000000000 -> 0x1000000000 and 9 -> 0x0000000009.
- Round-robin, all req held high, out_ready=1 -> grant order 0,1,2,3,0. Consecutive grants are 34 cycles apart, and out_id matches each grant.
- Backpressure, out_ready=0 for 5 cycles after out_valid -> bcd_out/out_id stable, busy=1, no gnt while req[3]=1. Grant to 3 happens the cycle after acceptance.
- Reset at SHIFT iteration 10 -> next cycle out_valid=0, busy=0, state IDLE. With req=1111, the next grant is 0001 (pointer reset) and that result is correct.
